// File: rtl/counter_cmd_loader.sv
// Serial command front-end for the 8-bit programmable counter.
// Receives 16-bit frames on an asynchronous 3-wire port and drives the counter's load, data and enable.
module counter_cmd_loader #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_cs,
  input  logic              ser_clk,
  input  logic              ser_din,
  output logic              load,
  output logic [DATA_W-1:0] load_data,
  output logic              cnt_enable,
  output logic              busy,
  output logic              frame_err
);

  localparam int FRAME_W = 8 + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_W);

  localparam logic [7:0] CMD_LOAD       = 8'h01;
  localparam logic [7:0] CMD_START      = 8'h02;
  localparam logic [7:0] CMD_STOP       = 8'h03;
  localparam logic [7:0] CMD_LOAD_START = 8'h04;
  localparam logic [7:0] CMD_CLR_ERR    = 8'h05;

  typedef enum logic [1:0] {IDLE, SHIFT, EXEC, DRAIN} state_e;

  logic [SYNC_STAGES-1:0] cs_sync_q,  cs_sync_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic                   cs_dly_q,   cs_dly_d;
  logic                   clk_dly_q,  clk_dly_d;
  logic [FRAME_W-1:0]     shift_q,    shift_d;
  logic [CNT_W-1:0]       bit_cnt_q,  bit_cnt_d;
  state_e                 state_q,    state_d;
  logic                   load_q,     load_d;
  logic [DATA_W-1:0]      load_data_q, load_data_d;
  logic                   cnt_enable_q, cnt_enable_d;
  logic                   busy_q,     busy_d;
  logic                   frame_err_q, frame_err_d;

  logic                   sync_cs, sync_clk, sync_din;
  logic                   bit_edge, capture;
  logic [CNT_W-1:0]       cnt_next;
  logic [7:0]             cmd;
  logic [DATA_W-1:0]      dat;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0],  ser_cs};
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ser_clk};
    din_sync_d = {din_sync_q[SYNC_STAGES-2:0], ser_din};
    sync_cs    = cs_sync_q[SYNC_STAGES-1];
    sync_clk   = clk_sync_q[SYNC_STAGES-1];
    sync_din   = din_sync_q[SYNC_STAGES-1];
    cs_dly_d   = sync_cs;
    clk_dly_d  = sync_clk;
    bit_edge   = sync_clk & ~clk_dly_q;
    // A bit edge arriving in the same cycle cs drops still belongs to the frame.
    capture    = bit_edge & (sync_cs | cs_dly_q);
    cnt_next   = (bit_cnt_q == FRAME_LEN) ? bit_cnt_q : bit_cnt_q + 1'b1;
    cmd        = shift_q[FRAME_W-1 -: 8];
    dat        = shift_q[DATA_W-1:0];

    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    state_d      = state_q;
    load_d       = 1'b0;
    load_data_d  = load_data_q;
    cnt_enable_d = cnt_enable_q;
    frame_err_d  = frame_err_q;

    unique case (state_q)
      IDLE: begin
        if (sync_cs && !cs_dly_q) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (capture) begin
          shift_d   = {shift_q[FRAME_W-2:0], sync_din};
          bit_cnt_d = cnt_next;
        end
        if (capture && cnt_next == FRAME_LEN) begin
          state_d = EXEC;
        end else if (!sync_cs) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      EXEC: begin
        state_d = DRAIN;
        case (cmd)
          CMD_LOAD: begin
            load_data_d = dat;
            load_d      = 1'b1;
          end
          CMD_START:   cnt_enable_d = 1'b1;
          CMD_STOP:    cnt_enable_d = 1'b0;
          CMD_LOAD_START: begin
            load_data_d  = dat;
            load_d       = 1'b1;
            cnt_enable_d = 1'b1;
          end
          CMD_CLR_ERR: frame_err_d = 1'b0;
          default:     frame_err_d = 1'b1;
        endcase
      end
      DRAIN: begin
        if (!sync_cs)      state_d     = IDLE;
        else if (bit_edge) frame_err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: rst_n is active-high in this codebase despite its name; reset is asynchronous.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cs_sync_q    <= '0;
      clk_sync_q   <= '0;
      din_sync_q   <= '0;
      cs_dly_q     <= 1'b0;
      clk_dly_q    <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      state_q      <= IDLE;
      load_q       <= 1'b0;
      load_data_q  <= '0;
      cnt_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      cs_sync_q    <= cs_sync_d;
      clk_sync_q   <= clk_sync_d;
      din_sync_q   <= din_sync_d;
      cs_dly_q     <= cs_dly_d;
      clk_dly_q    <= clk_dly_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      state_q      <= state_d;
      load_q       <= load_d;
      load_data_q  <= load_data_d;
      cnt_enable_q <= cnt_enable_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign load       = load_q;
  assign load_data  = load_data_q;
  assign cnt_enable = cnt_enable_q;
  assign busy       = busy_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_counter_cmd_loader.sv
// Bench for counter_cmd_loader: two instances (sync depth 2 and 3) share one serial host and are
// compared every cycle against a frame-level model that schedules each command's effect in time.
module tb_counter_cmd_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ser_cs = 1'b0, ser_clk = 1'b0, ser_din = 1'b0;
  logic       l2, en2, bz2, er2, l3, en3, bz3, er3;
  logic [7:0] ld2, ld3;

  counter_cmd_loader #(.SYNC_STAGES(2), .DATA_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ser_cs(ser_cs), .ser_clk(ser_clk), .ser_din(ser_din),
    .load(l2), .load_data(ld2), .cnt_enable(en2), .busy(bz2), .frame_err(er2));

  counter_cmd_loader #(.SYNC_STAGES(3), .DATA_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .ser_cs(ser_cs), .ser_clk(ser_clk), .ser_din(ser_din),
    .load(l3), .load_data(ld3), .cnt_enable(en3), .busy(bz3), .frame_err(er3));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: each command takes effect a fixed number of cycles after the raw ser_clk rise
  // that delivered its last bit (sync depth + 2), an error event sync depth + 1 after its cause.
  typedef enum int {K_LOAD, K_EN, K_DIS, K_LDEN, K_CLR, K_ERR} kind_e;
  typedef struct {
    int         at;
    int         who;
    kind_e      kind;
    logic [7:0] dat;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] m_ld   [2];
  logic       m_en   [2];
  logic       m_err  [2];
  logic       m_load [2];
  int         load_cnt  [2];
  int         last_load [2];
  int         last_c16;

  function automatic void sched(input int c, input int extra, input kind_e k, input logic [7:0] d);
    evq.push_back('{at: c + 2 + extra, who: 0, kind: k, dat: d});
    evq.push_back('{at: c + 3 + extra, who: 1, kind: k, dat: d});
  endfunction

  function automatic void sched_cmd(input int c16, input logic [7:0] cmd, input logic [7:0] dat);
    case (cmd)
      8'h01:   sched(c16, 2, K_LOAD, dat);
      8'h02:   sched(c16, 2, K_EN,   dat);
      8'h03:   sched(c16, 2, K_DIS,  dat);
      8'h04:   sched(c16, 2, K_LDEN, dat);
      8'h05:   sched(c16, 2, K_CLR,  dat);
      default: sched(c16, 2, K_ERR,  dat);
    endcase
  endfunction

  initial begin
    for (int w = 0; w < 2; w++) begin
      m_ld[w] = '0; m_en[w] = 1'b0; m_err[w] = 1'b0; m_load[w] = 1'b0;
      load_cnt[w] = 0; last_load[w] = -1;
    end
  end

  always @(negedge clk) begin
    m_load[0] = 1'b0;
    m_load[1] = 1'b0;
    if (rst_n) begin
      evq.delete();
      for (int w = 0; w < 2; w++) begin
        m_ld[w] = '0; m_en[w] = 1'b0; m_err[w] = 1'b0;
      end
    end else begin
      for (int i = evq.size() - 1; i >= 0; i--) begin
        if (evq[i].at <= cyc) begin
          case (evq[i].kind)
            K_LOAD: begin m_ld[evq[i].who] = evq[i].dat; m_load[evq[i].who] = 1'b1; end
            K_EN:   m_en[evq[i].who] = 1'b1;
            K_DIS:  m_en[evq[i].who] = 1'b0;
            K_LDEN: begin
              m_ld[evq[i].who] = evq[i].dat; m_load[evq[i].who] = 1'b1; m_en[evq[i].who] = 1'b1;
            end
            K_CLR:  m_err[evq[i].who] = 1'b0;
            K_ERR:  m_err[evq[i].who] = 1'b1;
            default: ;
          endcase
          evq.delete(i);
        end
      end
    end
    if (l2) begin load_cnt[0]++; last_load[0] = cyc; end
    if (l3) begin load_cnt[1]++; last_load[1] = cyc; end
    check("s2_load",       l2,  m_load[0]);
    check("s2_load_data",  ld2, m_ld[0]);
    check("s2_cnt_enable", en2, m_en[0]);
    check("s2_frame_err",  er2, m_err[0]);
    check("s3_load",       l3,  m_load[1]);
    check("s3_load_data",  ld3, m_ld[1]);
    check("s3_cnt_enable", en3, m_en[1]);
    check("s3_frame_err",  er3, m_err[1]);
  end

  // cs_mode: 0 = normal deselect, 1 = deselect lands during EXEC, 2 = deselect with the 16th rise.
  task automatic send(input logic [7:0] cmd, input logic [7:0] dat, input logic [7:0] extra,
                      input int n, input int cs_mode);
    logic [23:0] fr;
    int lo, hi, c_fall;
    fr = {cmd, dat, extra};
    c_fall = 0;
    @(negedge clk);
    ser_cs  = 1'b1;
    ser_din = fr[23];
    repeat ($urandom_range(2, 4)) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      ser_din = fr[23 - i];
      lo = $urandom_range(4, 7);
      hi = $urandom_range(4, 7);
      repeat (lo) @(negedge clk);
      ser_clk = 1'b1;
      if (i == 15) begin
        last_c16 = cyc;
        sched_cmd(cyc, cmd, dat);
        if (cs_mode == 2) ser_cs = 1'b0;
      end
      if (i >= 16) sched(cyc, 1, K_ERR, 8'h00);
      if (i == 15 && cs_mode == 1) begin
        @(negedge clk);
        ser_cs = 1'b0;
        hi--;
      end
      repeat (hi) @(negedge clk);
      if (i == 0) begin
        check("s2_busy_mid_frame", bz2, 1'b1);
        check("s3_busy_mid_frame", bz3, 1'b1);
      end
      ser_clk = 1'b0;
    end
    if (ser_cs) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      c_fall = cyc;
      ser_cs = 1'b0;
      if (n < 16) sched(c_fall, 1, K_ERR, 8'h00);
    end
    repeat (12) @(negedge clk);
    check("s2_busy_idle", bz2, 1'b0);
    check("s3_busy_idle", bz3, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  int pre_loads;

  initial begin
    logic [7:0] cmd, dat;
    int n, mode, r;

    repeat (3) @(negedge clk);
    check("reset_load",      l2,  1'b0);
    check("reset_load_data", ld2, 8'h00);
    check("reset_busy",      bz2, 1'b0);
    check("reset_frame_err", er3, 1'b0);
    #1 rst_n = 1'b0;

    // Reset mid-frame after 7 bits with cs still asserted.
    repeat (4) @(negedge clk);
    ser_cs = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      ser_din = 1'b1;
      repeat (5) @(negedge clk);
      ser_clk = 1'b1;
      repeat (5) @(negedge clk);
      ser_clk = 1'b0;
    end
    check("midframe_busy", bz3, 1'b1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    ser_cs = 1'b0; ser_clk = 1'b0; ser_din = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy2", bz2, 1'b0);
    check("midrst_busy3", bz3, 1'b0);
    check("midrst_err",   er2, 1'b0);
    check("midrst_en",    en3, 1'b0);
    #1 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    send(8'h01, 8'h5A, 8'h00, 16, 0);
    check("post_reset_load_5a", ld2, 8'h5A);

    // LOAD 0xA5: one pulse, enable untouched, latency from raw rise = depth + 2.
    pre_loads = load_cnt[0];
    send(8'h01, 8'hA5, 8'h00, 16, 0);
    check("load_a5_data",    ld2, 8'hA5);
    check("load_a5_data_s3", ld3, 8'hA5);
    check("load_a5_enable",  en2, 1'b0);
    check("load_a5_pulses",  load_cnt[0] - pre_loads, 1);
    check("latency_s2",      last_load[0] - last_c16, 4);
    check("latency_s3",      last_load[1] - last_c16, 5);

    // LOAD_START then STOP.
    send(8'h04, 8'h3C, 8'h00, 16, 0);
    check("ldst_data",   ld2, 8'h3C);
    check("ldst_enable", en2, 1'b1);
    check("ldst_same_cycle", last_load[0] - last_c16, 4);
    pre_loads = load_cnt[0];
    send(8'h03, 8'h00, 8'h00, 16, 0);
    check("stop_enable", en2, 1'b0);
    check("stop_data",   ld2, 8'h3C);
    check("stop_no_load", load_cnt[0] - pre_loads, 0);

    // Short frame then CLR_ERR.
    send(8'h01, 8'hFF, 8'h00, 10, 0);
    check("short_err",  er2, 1'b1);
    check("short_data", ld2, 8'h3C);
    send(8'h05, 8'h00, 8'h00, 16, 0);
    check("clr_err", er2, 1'b0);

    // Overlong START and illegal command.
    send(8'h02, 8'hFF, 8'hC0, 18, 0);
    check("long_enable", en2, 1'b1);
    check("long_err",    er2, 1'b1);
    send(8'h05, 8'h00, 8'h00, 16, 0);
    check("clr_err2", er3, 1'b0);
    send(8'h7E, 8'h12, 8'h00, 16, 0);
    check("illegal_err",  er2, 1'b1);
    check("illegal_data", ld2, 8'h3C);
    check("illegal_en",   en2, 1'b1);

    // CLR_ERR with a trailing bit re-sets the flag.
    send(8'h05, 8'h00, 8'h80, 17, 0);
    check("clr_extra_err", er2, 1'b1);

    // Deselect during EXEC and coincident with the 16th rise.
    send(8'h01, 8'h11, 8'h00, 16, 1);
    check("cs_exec_data", ld3, 8'h11);
    send(8'h01, 8'h22, 8'h00, 16, 2);
    check("cs_same_edge_data", ld3, 8'h22);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    cmd = 8'h01;
        2:       cmd = 8'h02;
        3:       cmd = 8'h03;
        4, 5:    cmd = 8'h04;
        6, 7:    cmd = 8'h05;
        default: cmd = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(6, 255));
      endcase
      dat = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0)      n = $urandom_range(1, 15);
      else if (r == 1) n = $urandom_range(17, 20);
      else             n = 16;
      mode = (n == 16) ? $urandom_range(0, 2) : 0;
      send(cmd, dat, 8'($urandom), n, mode);
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
